// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci generator and its pair serializer.
package fib_pkg;

    localparam int FIB_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } fib_ser_state_t;

endpackage

// File: rtl/fib_seq_checker.sv
// Sticky monitor: every transferred word after the first two must be the
// modulo-2^W sum of the two words transferred before it.
module fib_seq_checker
    import fib_pkg::*;
#(
    parameter int W = FIB_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         xfer,
    input  logic [W-1:0] data,
    output logic         seq_err
);

    logic [W-1:0] r_p1;
    logic [W-1:0] r_p2;
    logic [1:0]   r_cnt;
    logic         r_err;
    logic [W-1:0] w_sum;

    assign w_sum   = r_p1 + r_p2;
    assign seq_err = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1  <= '0;
            r_p2  <= '0;
            r_cnt <= 2'd0;
            r_err <= 1'b0;
        end else if (xfer) begin
            r_p2 <= r_p1;
            r_p1 <= data;
            if (r_cnt != 2'd2) begin
                r_cnt <= r_cnt + 2'd1;
            end else if (data != w_sum) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fib_pair_serializer.sv
// Two-word-to-one-word stream serializer for Fibonacci pairs (a first, then b).
// Optional recurrence checker enabled by defining FIB_SER_SEQ_CHECK_EN.
module fib_pair_serializer
    import fib_pkg::*;
#(
    parameter int W = FIB_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_second,
    output logic         seq_err
);

    fib_ser_state_t r_state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic           r_out_second;
    logic           w_out_xfer;
    logic           w_in_xfer;

    // Refill while draining b so back-to-back pairs stream without a bubble.
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            EMPTY:   in_ready = 1'b1;
            HOLD_A:  in_ready = 1'b0;
            HOLD_B:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_second = r_out_second;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            a_q          <= '0;
            b_q          <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_second <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        a_q          <= in_a;
                        b_q          <= in_b;
                        r_state      <= HOLD_A;
                        r_out_valid  <= 1'b1;
                        r_out_data   <= in_a;
                        r_out_second <= 1'b0;
                    end
                end
                HOLD_A: begin
                    if (w_out_xfer) begin
                        r_state      <= HOLD_B;
                        r_out_data   <= b_q;
                        r_out_second <= 1'b1;
                    end
                end
                HOLD_B: begin
                    if (w_out_xfer) begin
                        if (w_in_xfer) begin
                            a_q          <= in_a;
                            b_q          <= in_b;
                            r_state      <= HOLD_A;
                            r_out_data   <= in_a;
                            r_out_second <= 1'b0;
                        end else begin
                            r_state      <= EMPTY;
                            r_out_valid  <= 1'b0;
                            r_out_second <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= EMPTY;
                    r_out_valid  <= 1'b0;
                    r_out_second <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIB_SER_SEQ_CHECK_EN
    fib_seq_checker #(.W(W)) u_seq_checker (
        .clk     (clk),
        .rst_n   (rst_n),
        .xfer    (w_out_xfer),
        .data    (r_out_data),
        .seq_err (seq_err)
    );
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Self-checking bench: queue-based stream model plus directed pair sequences.
module tb_fib_pair_serializer;

    localparam int W = 16;
`ifdef FIB_SER_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_second;
    logic         seq_err;

    always #5 clk = ~clk;

    fib_pair_serializer #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_second (out_second),
        .seq_err    (seq_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         sec;
    } word_t;

    word_t        q[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] log_d[$];
    bit           m_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending words in a queue, history of transferred words.
    always @(negedge clk) begin
        bit           exp_rdy;
        bit           out_f;
        bit           in_f;
        word_t        w;
        logic [W-1:0] s;
        if (!rst_n) begin
            q.delete();
            hist.delete();
            m_err = 1'b0;
        end else begin
            exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(q[0].d));
                chk("out_second", 32'(out_second), 32'(q[0].sec));
            end
            chk("seq_err", 32'(seq_err), 32'(m_err));
            out_f = (q.size() != 0) && out_ready;
            in_f  = in_valid && exp_rdy;
            if (out_f) begin
                w = q.pop_front();
                log_d.push_back(w.d);
                if (hist.size() >= 2) begin
                    s = hist[hist.size()-1] + hist[hist.size()-2];
                    if (CHK && w.d != s) m_err = 1'b1;
                end
                hist.push_back(w.d);
                if (hist.size() > 2) void'(hist.pop_front());
            end
            if (in_f) begin
                q.push_back('{d: in_a, sec: 1'b0});
                q.push_back('{d: in_b, sec: 1'b1});
            end
        end
    end

    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        int k;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        k        = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            k++;
            if (k > 20) begin
                chk("send_timeout", 32'(k), 32'd0);
                break;
            end
        end
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0;
        k        = 0;
        forever begin
            @(negedge clk);
            if (!out_valid) break;
            k++;
            if (k > 50) begin
                chk("drain_timeout", 32'(k), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_log(input string nm, input logic [W-1:0] exp[$]);
        chk({nm, "_len"}, 32'(log_d.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_d.size(); i++)
            chk(nm, 32'(log_d[i]), 32'(exp[i]));
    endtask

    initial begin
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_second", 32'(out_second), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Streaming pairs
        log_d.delete();
        send_pair(16'd1, 16'd1);
        send_pair(16'd2, 16'd3);
        send_pair(16'd5, 16'd8);
        drain();
        chk_log("stream", '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8});
        chk("stream_seq_err", 32'(seq_err), 32'd0);

        // Backpressure
        do_reset();
        log_d.delete();
        out_ready = 1'b0;
        send_pair(16'd13, 16'd21);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_data", 32'(out_data), 32'd13);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'd34;
        in_b      = 16'd55;
        @(negedge clk);
        chk("bp_rel_a", 32'(out_data), 32'd13);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_rel_b", 32'(out_data), 32'd21);
        chk("bp_refill_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        drain();
        chk_log("bp", '{16'd13, 16'd21, 16'd34, 16'd55});

        // Wrap-around modulo 2^16
        do_reset();
        log_d.delete();
        send_pair(16'd28657, 16'd46368);
        send_pair(16'd9489, 16'd55857);
        drain();
        chk_log("wrap", '{16'd28657, 16'd46368, 16'd9489, 16'd55857});
        chk("wrap_seq_err", 32'(seq_err), 32'd0);

        // Fault injection: 4 where 3 is due
        do_reset();
        log_d.delete();
        send_pair(16'd1, 16'd1);
        send_pair(16'd2, 16'd4);
        send_pair(16'd6, 16'd10);
        drain();
        chk_log("fault", '{16'd1, 16'd1, 16'd2, 16'd4, 16'd6, 16'd10});
        chk("fault_seq_err", 32'(seq_err), 32'(CHK));

        // Reset in HOLD_B holding 8
        log_d.delete();
        send_pair(16'd5, 16'd8);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("hb_data", 32'(out_data), 32'd8);
        chk("hb_second", 32'(out_second), 32'd1);
        chk("hb_seq_err_sticky", 32'(seq_err), 32'(CHK));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_seq_err", 32'(seq_err), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        log_d.delete();
        send_pair(16'd1, 16'd1);
        drain();
        chk_log("post_rst", '{16'd1, 16'd1});
        chk("post_rst_seq_err", 32'(seq_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0t expected finish", $time);
        $fatal(1);
    end

endmodule
